// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl: round-robin write arbitration of NUM_REQ producers onto a
// single shared FIFO, with read/write enables gated by a local occupancy count.
module fifo_share_ctrl #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 16,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1,
    localparam int PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          rd_req,
    output logic                          rd_valid,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_d_in,
    output logic                          fifo_r_en,
    output logic [CW-1:0]                 count,
    output logic                          full,
    output logic                          empty
);

    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_count;
    logic          r_rd_valid;

    logic          w_wr_ok;
    logic          w_found;
    logic [PW-1:0] w_gnt_idx;
    logic [PW-1:0] w_ptr_next;

    assign full      = (r_count == CW'(FIFO_DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rd_valid  = r_rd_valid;

    // A read at full does not free a slot in the same cycle, so writes are
    // gated purely on the registered count.
    assign w_wr_ok   = ~full & ~reset;
    assign fifo_r_en = rd_req & ~empty & ~reset;
    assign fifo_w_en = w_found;

    // Round-robin scan starting at r_ptr; first asserted request wins.
    always_comb begin
        int unsigned idx;
        gnt       = '0;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        idx       = 0;
        if (w_wr_ok) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = 32'(r_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!w_found && req[idx]) begin
                    w_found   = 1'b1;
                    gnt[idx]  = 1'b1;
                    w_gnt_idx = PW'(idx);
                end
            end
        end
    end

    // Data mux for the granted producer and wrapped pointer successor.
    always_comb begin
        fifo_d_in  = '0;
        w_ptr_next = r_ptr;
        if (w_found) begin
            fifo_d_in = req_data[32'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            if (32'(w_gnt_idx) == NUM_REQ - 1) begin
                w_ptr_next = '0;
            end else begin
                w_ptr_next = w_gnt_idx + 1'b1;
            end
        end
    end

    // Pointer, occupancy and read-valid state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_ptr      <= w_ptr_next;
            r_rd_valid <= fifo_r_en;
            case ({fifo_w_en, fifo_r_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Directed bench for fifo_share_ctrl (NUM_REQ=4, DATA_WIDTH=8, FIFO_DEPTH=16).
module tb_fifo_share_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        rd_req;
    logic        rd_valid;
    logic        fifo_w_en;
    logic [7:0]  fifo_d_in;
    logic        fifo_r_en;
    logic [4:0]  count;
    logic        full;
    logic        empty;

    int vectors;
    int miscompares;

    logic [7:0] q[$];

    fifo_share_ctrl #(
        .NUM_REQ   (4),
        .DATA_WIDTH(8),
        .FIFO_DEPTH(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .rd_req   (rd_req),
        .rd_valid (rd_valid),
        .fifo_w_en(fifo_w_en),
        .fifo_d_in(fifo_d_in),
        .fifo_r_en(fifo_r_en),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural FIFO contents as seen through the write/read enables.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
        end else begin
            if (fifo_w_en) q.push_back(fifo_d_in);
            if (fifo_r_en && q.size() > 0) void'(q.pop_front());
        end
    end

    task automatic test_reset;
        reset    = 1'b1;
        req      = 4'b1111;
        rd_req   = 1'b1;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({gnt, fifo_w_en, fifo_r_en} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_enables: got gnt=%b w=%b r=%b want 0000 0 0", gnt, fifo_w_en, fifo_r_en);
            end
            vectors++;
            if ({count, empty, full, rd_valid} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_state: got count=%0d empty=%b full=%b rv=%b want 0 1 0 0", count, empty, full, rd_valid);
            end
        end
        @(negedge clk);
        reset  = 1'b0;
        req    = 4'b0000;
        rd_req = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [3:0] eg;
        logic [7:0] ed;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            eg = 4'b0001 << i;
            ed = 8'hA0 + 8'(i);
            #1;
            vectors++;
            if ({gnt, fifo_w_en, fifo_d_in} !== {eg, 1'b1, ed}) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got gnt=%b w=%b d=%h want %b 1 %h", i, gnt, fifo_w_en, fifo_d_in, eg, ed);
            end
            @(posedge clk); #1;
            vectors++;
            if (count !== 5'(i + 1)) begin
                miscompares++;
                $display("FAIL rr_count%0d: got %0d want %0d", i, count, i + 1);
            end
            @(negedge clk);
        end
        req = 4'b0000;
        #1;
        vectors++;
        if (q.size() != 4) begin
            miscompares++;
            $display("FAIL rr_fifo_size: got %0d want 4", q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                ed = 8'hA0 + 8'(i);
                vectors++;
                if (q[i] !== ed) begin
                    miscompares++;
                    $display("FAIL rr_fifo_word%0d: got %h want %h", i, q[i], ed);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_wrap_skip;
        // grant index 2 moves the pointer to 3
        req = 4'b0100;
        #1;
        vectors++;
        if (gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL wrap_setup: got %b want 0100", gnt);
        end
        @(negedge clk);
        req = 4'b0101;
        #1;
        vectors++;
        if ({gnt, fifo_d_in} !== {4'b0001, 8'hA0}) begin
            miscompares++;
            $display("FAIL wrap_grant: got gnt=%b d=%h want 0001 a0", gnt, fifo_d_in);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({gnt, fifo_d_in} !== {4'b0100, 8'hA2}) begin
            miscompares++;
            $display("FAIL skip_grant: got gnt=%b d=%h want 0100 a2", gnt, fifo_d_in);
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        vectors++;
        if (count !== 5'd7) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d want 7", count);
        end
    endtask

    task automatic test_async_reset;
        // pointer is 3 and count is 7 here; reset pulses with no clock edge
        @(negedge clk);
        #1 reset = 1'b1;
        req = 4'b1111;
        #1;
        vectors++;
        if ({count, empty, full} !== {5'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL areset_state: got count=%0d empty=%b full=%b want 0 1 0", count, empty, full);
        end
        vectors++;
        if ({gnt, fifo_w_en} !== 5'b0) begin
            miscompares++;
            $display("FAIL areset_gate: got gnt=%b w=%b want 0000 0", gnt, fifo_w_en);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL areset_ptr: got %b want 0001", gnt);
        end
        req = 4'b1000;
        #1;
        vectors++;
        if ({gnt, fifo_d_in} !== {4'b1000, 8'hA3}) begin
            miscompares++;
            $display("FAIL areset_grant: got gnt=%b d=%h want 1000 a3", gnt, fifo_d_in);
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        vectors++;
        if ({count, q.size() == 1} !== {5'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL areset_after: got count=%0d qsize=%0d want 1 1", count, q.size());
        end
    endtask

    task automatic test_empty;
        rd_req = 1'b1;
        #1;
        vectors++;
        if (fifo_r_en !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_ren: got %b want 1", fifo_r_en);
        end
        @(posedge clk); #1;
        vectors++;
        if ({count, empty, rd_valid} !== {5'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL drain_state: got count=%0d empty=%b rv=%b want 0 1 1", count, empty, rd_valid);
        end
        @(negedge clk);
        req = 4'b0010;
        #1;
        vectors++;
        if ({fifo_r_en, gnt, fifo_w_en, fifo_d_in} !== {1'b0, 4'b0010, 1'b1, 8'hA1}) begin
            miscompares++;
            $display("FAIL empty_gate: got r=%b gnt=%b w=%b d=%h want 0 0010 1 a1", fifo_r_en, gnt, fifo_w_en, fifo_d_in);
        end
        @(posedge clk); #1;
        vectors++;
        if ({count, empty, rd_valid} !== {5'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL empty_after: got count=%0d empty=%b rv=%b want 1 0 0", count, empty, rd_valid);
        end
        @(negedge clk);
        req    = 4'b0000;
        rd_req = 1'b0;
    endtask

    task automatic test_full;
        req = 4'b0001;
        for (int i = 0; i < 15; i++) begin
            #1;
            vectors++;
            if (gnt !== 4'b0001) begin
                miscompares++;
                $display("FAIL fill_grant%0d: got %b want 0001", i, gnt);
            end
            @(negedge clk);
        end
        #1;
        vectors++;
        if ({count, full, gnt, fifo_w_en} !== {5'd16, 1'b1, 4'b0000, 1'b0}) begin
            miscompares++;
            $display("FAIL full_block: got count=%0d full=%b gnt=%b w=%b want 16 1 0000 0", count, full, gnt, fifo_w_en);
        end
        rd_req = 1'b1;
        #1;
        vectors++;
        if ({gnt, fifo_w_en, fifo_r_en} !== {4'b0000, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL full_rd: got gnt=%b w=%b r=%b want 0000 0 1", gnt, fifo_w_en, fifo_r_en);
        end
        @(posedge clk); #1;
        vectors++;
        if ({count, full} !== {5'd15, 1'b0}) begin
            miscompares++;
            $display("FAIL full_after_rd: got count=%0d full=%b want 15 0", count, full);
        end
        @(negedge clk);
        #1;
        vectors++;
        if ({gnt, fifo_w_en, fifo_r_en} !== {4'b0001, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_enables: got gnt=%b w=%b r=%b want 0001 1 1", gnt, fifo_w_en, fifo_r_en);
        end
        @(posedge clk); #1;
        vectors++;
        if ({count, rd_valid} !== {5'd15, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_count: got count=%0d rv=%b want 15 1", count, rd_valid);
        end
        @(negedge clk);
        rd_req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({count, full, rd_valid} !== {5'd16, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL refill: got count=%0d full=%b rv=%b want 16 1 0", count, full, rd_valid);
        end
        @(negedge clk);
        req = 4'b0000;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        req         = '0;
        req_data    = '0;
        rd_req      = 1'b0;
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_async_reset();
        test_empty();
        test_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
